// File: rtl/hazard_stall_unit.sv
// Pipeline stall, bubble and freeze control with branch-stall sequencing
// and saturating stall-cycle counters.
module hazard_stall_unit #(
   parameter int CNT_W  = 32,
   parameter bit BR3_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IF_ID_rs1_i,
   input  logic [4:0]       IF_ID_rs2_i,
   input  logic [6:0]       IF_ID_opcode_i,
   input  logic [4:0]       ID_EX_rd_i,
   input  logic [6:0]       ID_EX_opcode_i,
   input  logic             EX_load_regfile_i,
   input  logic [4:0]       EX_MEM_rd_i,
   input  logic [6:0]       EX_MEM_opcode_i,
   input  logic             MEM_load_regfile_i,
   input  logic             br_taken_i,
   input  logic             imem_read_i,
   input  logic             imem_resp_i,
   input  logic             dmem_read_i,
   input  logic             dmem_write_i,
   input  logic             dmem_resp_i,
   output logic             pc_load_o,
   output logic             IF_ID_load_o,
   output logic             ID_EX_load_o,
   output logic             EX_MEM_load_o,
   output logic             MEM_WB_load_o,
   output logic             IF_ID_flush_o,
   output logic             controlmux_sel_o,
   output logic             stall_br_haz1_o,
   output logic             stall_br_haz2_o,
   output logic [CNT_W-1:0] lu_stall_cnt_o,
   output logic [CNT_W-1:0] br_stall_cnt_o,
   output logic [CNT_W-1:0] mem_stall_cnt_o
);

   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef enum logic [1:0] {
      S_RUN = 2'd0,
      S_BR2 = 2'd1,
      S_BR1 = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_lu_cnt;
   logic [CNT_W-1:0] r_br_cnt;
   logic [CNT_W-1:0] r_mem_cnt;

   logic w_use_rs1;
   logic w_use_rs2;
   logic w_ex_dep;
   logic w_mem_dep;
   logic w_br_id;
   logic w_lu;
   logic w_bh2;
   logic w_bh1;
   logic w_dmem_busy;
   logic w_imem_busy;
   logic w_inc_lu;
   logic w_inc_br;
   logic w_inc_mem;

   assign w_use_rs1 = IF_ID_opcode_i inside
      {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BR, OP_JALR};
   assign w_use_rs2 = IF_ID_opcode_i inside {OP_REG, OP_STORE, OP_BR};

   // x0 is never a real producer, so rd == 0 is excluded
   assign w_ex_dep = EX_load_regfile_i && (ID_EX_rd_i != 5'd0) &&
      ((w_use_rs1 && (ID_EX_rd_i == IF_ID_rs1_i)) ||
       (w_use_rs2 && (ID_EX_rd_i == IF_ID_rs2_i)));
   assign w_mem_dep = MEM_load_regfile_i && (EX_MEM_rd_i != 5'd0) &&
      ((w_use_rs1 && (EX_MEM_rd_i == IF_ID_rs1_i)) ||
       (w_use_rs2 && (EX_MEM_rd_i == IF_ID_rs2_i)));

   assign w_br_id     = (IF_ID_opcode_i == OP_BR) ||
                        (IF_ID_opcode_i == OP_JALR);
   assign w_lu        = !w_br_id && (ID_EX_opcode_i == OP_LOAD) && w_ex_dep;
   assign w_bh2       = w_br_id && (ID_EX_opcode_i == OP_LOAD) && w_ex_dep;
   assign w_bh1       = w_br_id && (EX_MEM_opcode_i == OP_LOAD) && w_mem_dep;
   assign w_dmem_busy = (dmem_read_i || dmem_write_i) && !dmem_resp_i;
   assign w_imem_busy = imem_read_i && !imem_resp_i;

   // Prioritised control decode, next state and counter select
   always_comb begin
      pc_load_o        = 1'b1;
      IF_ID_load_o     = 1'b1;
      ID_EX_load_o     = 1'b1;
      EX_MEM_load_o    = 1'b1;
      MEM_WB_load_o    = 1'b1;
      IF_ID_flush_o    = 1'b0;
      controlmux_sel_o = 1'b0;
      stall_br_haz1_o  = 1'b0;
      stall_br_haz2_o  = 1'b0;
      w_next           = r_state;
      w_inc_lu         = 1'b0;
      w_inc_br         = 1'b0;
      w_inc_mem        = 1'b0;
      if (rst) begin
         pc_load_o     = 1'b0;
         IF_ID_load_o  = 1'b0;
         ID_EX_load_o  = 1'b0;
         EX_MEM_load_o = 1'b0;
         MEM_WB_load_o = 1'b0;
         w_next        = S_RUN;
      end else if (w_dmem_busy) begin
         pc_load_o       = 1'b0;
         IF_ID_load_o    = 1'b0;
         ID_EX_load_o    = 1'b0;
         EX_MEM_load_o   = 1'b0;
         MEM_WB_load_o   = 1'b0;
         stall_br_haz1_o = (r_state == S_BR1);
         stall_br_haz2_o = (r_state == S_BR2);
         w_inc_mem       = 1'b1;
      end else if (r_state == S_BR1) begin
         pc_load_o        = 1'b0;
         IF_ID_load_o     = 1'b0;
         controlmux_sel_o = 1'b1;
         stall_br_haz1_o  = 1'b1;
         w_next           = S_RUN;
         w_inc_br         = 1'b1;
      end else if (r_state == S_BR2) begin
         pc_load_o        = 1'b0;
         IF_ID_load_o     = 1'b0;
         controlmux_sel_o = 1'b1;
         stall_br_haz2_o  = 1'b1;
         w_next           = S_BR1;
         w_inc_br         = 1'b1;
      end else begin
         unique case (1'b1)
            w_bh2: begin
               pc_load_o        = 1'b0;
               IF_ID_load_o     = 1'b0;
               controlmux_sel_o = 1'b1;
               stall_br_haz2_o  = 1'b1;
               w_next           = BR3_EN ? S_BR2 : S_BR1;
               w_inc_br         = 1'b1;
            end
            (w_bh1 && !w_bh2): begin
               pc_load_o        = 1'b0;
               IF_ID_load_o     = 1'b0;
               controlmux_sel_o = 1'b1;
               stall_br_haz1_o  = 1'b1;
               w_next           = S_BR1;
               w_inc_br         = 1'b1;
            end
            (w_lu && !w_bh1 && !w_bh2): begin
               pc_load_o        = 1'b0;
               IF_ID_load_o     = 1'b0;
               controlmux_sel_o = 1'b1;
               w_inc_lu         = 1'b1;
            end
            (w_imem_busy && !w_lu && !w_bh1 && !w_bh2): begin
               pc_load_o     = 1'b0;
               IF_ID_flush_o = 1'b1;
               w_inc_mem     = 1'b1;
            end
            (br_taken_i && !w_imem_busy && !w_lu && !w_bh1 && !w_bh2): begin
               IF_ID_flush_o = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // State register and saturating stall counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_RUN;
         r_lu_cnt  <= '0;
         r_br_cnt  <= '0;
         r_mem_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_inc_lu && (r_lu_cnt != '1))
            r_lu_cnt <= r_lu_cnt + CNT_W'(1);
         if (w_inc_br && (r_br_cnt != '1))
            r_br_cnt <= r_br_cnt + CNT_W'(1);
         if (w_inc_mem && (r_mem_cnt != '1))
            r_mem_cnt <= r_mem_cnt + CNT_W'(1);
      end
   end

   assign lu_stall_cnt_o  = r_lu_cnt;
   assign br_stall_cnt_o  = r_br_cnt;
   assign mem_stall_cnt_o = r_mem_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit.
// Output vector order: pc,ifid,idex,exmem,memwb,flush,cmux,haz1,haz2.
module tb_hazard_stall_unit;

   localparam logic [6:0] OP_REG  = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [8:0] V_ZERO = 9'b00000_0000;
   localparam logic [8:0] V_NORM = 9'b11111_0000;
   localparam logic [8:0] V_LU   = 9'b00111_0100;
   localparam logic [8:0] V_BH2  = 9'b00111_0101;
   localparam logic [8:0] V_BH1  = 9'b00111_0110;
   localparam logic [8:0] V_DBR1 = 9'b00000_0010;
   localparam logic [8:0] V_IMIS = 9'b01111_1000;
   localparam logic [8:0] V_BRT  = 9'b11111_1000;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] IF_ID_rs1_i, IF_ID_rs2_i, ID_EX_rd_i, EX_MEM_rd_i;
   logic [6:0] IF_ID_opcode_i, ID_EX_opcode_i, EX_MEM_opcode_i;
   logic EX_load_regfile_i, MEM_load_regfile_i, br_taken_i;
   logic imem_read_i, imem_resp_i;
   logic dmem_read_i, dmem_write_i, dmem_resp_i;
   logic pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o;
   logic MEM_WB_load_o, IF_ID_flush_o, controlmux_sel_o;
   logic stall_br_haz1_o, stall_br_haz2_o;
   logic [31:0] lu_cnt, br_cnt, mem_cnt;
   logic s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_fl, s_cm, s_h1, s_h2;
   logic [1:0] s_lu, s_br, s_mem;
   logic [8:0] w_o;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_lu  = 0;
   int exp_br  = 0;
   int exp_mem = 0;

   always #5 clk = ~clk;

   hazard_stall_unit #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .IF_ID_rs1_i(IF_ID_rs1_i), .IF_ID_rs2_i(IF_ID_rs2_i),
      .IF_ID_opcode_i(IF_ID_opcode_i),
      .ID_EX_rd_i(ID_EX_rd_i), .ID_EX_opcode_i(ID_EX_opcode_i),
      .EX_load_regfile_i(EX_load_regfile_i),
      .EX_MEM_rd_i(EX_MEM_rd_i), .EX_MEM_opcode_i(EX_MEM_opcode_i),
      .MEM_load_regfile_i(MEM_load_regfile_i),
      .br_taken_i(br_taken_i),
      .imem_read_i(imem_read_i), .imem_resp_i(imem_resp_i),
      .dmem_read_i(dmem_read_i), .dmem_write_i(dmem_write_i),
      .dmem_resp_i(dmem_resp_i),
      .pc_load_o(pc_load_o), .IF_ID_load_o(IF_ID_load_o),
      .ID_EX_load_o(ID_EX_load_o), .EX_MEM_load_o(EX_MEM_load_o),
      .MEM_WB_load_o(MEM_WB_load_o), .IF_ID_flush_o(IF_ID_flush_o),
      .controlmux_sel_o(controlmux_sel_o),
      .stall_br_haz1_o(stall_br_haz1_o), .stall_br_haz2_o(stall_br_haz2_o),
      .lu_stall_cnt_o(lu_cnt), .br_stall_cnt_o(br_cnt),
      .mem_stall_cnt_o(mem_cnt)
   );

   hazard_stall_unit #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .IF_ID_rs1_i(IF_ID_rs1_i), .IF_ID_rs2_i(IF_ID_rs2_i),
      .IF_ID_opcode_i(IF_ID_opcode_i),
      .ID_EX_rd_i(ID_EX_rd_i), .ID_EX_opcode_i(ID_EX_opcode_i),
      .EX_load_regfile_i(EX_load_regfile_i),
      .EX_MEM_rd_i(EX_MEM_rd_i), .EX_MEM_opcode_i(EX_MEM_opcode_i),
      .MEM_load_regfile_i(MEM_load_regfile_i),
      .br_taken_i(br_taken_i),
      .imem_read_i(imem_read_i), .imem_resp_i(imem_resp_i),
      .dmem_read_i(dmem_read_i), .dmem_write_i(dmem_write_i),
      .dmem_resp_i(dmem_resp_i),
      .pc_load_o(s_pc), .IF_ID_load_o(s_ifid),
      .ID_EX_load_o(s_idex), .EX_MEM_load_o(s_exmem),
      .MEM_WB_load_o(s_memwb), .IF_ID_flush_o(s_fl),
      .controlmux_sel_o(s_cm),
      .stall_br_haz1_o(s_h1), .stall_br_haz2_o(s_h2),
      .lu_stall_cnt_o(s_lu), .br_stall_cnt_o(s_br),
      .mem_stall_cnt_o(s_mem)
   );

   assign w_o = {pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o,
                 MEM_WB_load_o, IF_ID_flush_o, controlmux_sel_o,
                 stall_br_haz1_o, stall_br_haz2_o};

   task automatic clear_in();
      IF_ID_rs1_i = 0; IF_ID_rs2_i = 0; IF_ID_opcode_i = 0;
      ID_EX_rd_i = 0; ID_EX_opcode_i = 0; EX_load_regfile_i = 0;
      EX_MEM_rd_i = 0; EX_MEM_opcode_i = 0; MEM_load_regfile_i = 0;
      br_taken_i = 0; imem_read_i = 0; imem_resp_i = 0;
      dmem_read_i = 0; dmem_write_i = 0; dmem_resp_i = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [6:0] op, input logic [4:0] a,
                         input logic [4:0] b);
      IF_ID_opcode_i = op; IF_ID_rs1_i = a; IF_ID_rs2_i = b;
   endtask

   task automatic set_ex(input logic [6:0] op, input logic [4:0] rd,
                         input logic we);
      ID_EX_opcode_i = op; ID_EX_rd_i = rd; EX_load_regfile_i = we;
   endtask

   task automatic set_mem(input logic [6:0] op, input logic [4:0] rd,
                          input logic we);
      EX_MEM_opcode_i = op; EX_MEM_rd_i = rd; MEM_load_regfile_i = we;
   endtask

   task automatic test_reset();
      clear_in();
      rst = 1'b1;
      #2;
      tick();
      n_tests++;
      if (w_o !== V_ZERO) begin
         n_fail++;
         $display("FAIL reset_outs got=%b exp=%b", w_o, V_ZERO);
      end
      n_tests++;
      if (lu_cnt !== 0 || br_cnt !== 0 || mem_cnt !== 0) begin
         n_fail++;
         $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0",
                  lu_cnt, br_cnt, mem_cnt);
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (w_o !== V_NORM) begin
         n_fail++;
         $display("FAIL reset_release got=%b exp=%b", w_o, V_NORM);
      end
   endtask

   task automatic test_load_use();
      tick();
      set_ex(OP_LOAD, 5'd5, 1'b1);
      set_id(OP_REG, 5'd5, 5'd1);
      #1;
      n_tests++;
      if (w_o !== V_LU) begin
         n_fail++;
         $display("FAIL lu_stall got=%b exp=%b", w_o, V_LU);
      end
      tick();
      exp_lu++;
      set_ex(7'd0, 5'd0, 1'b0);
      set_mem(OP_LOAD, 5'd5, 1'b1);
      #1;
      n_tests++;
      if (w_o !== V_NORM) begin
         n_fail++;
         $display("FAIL lu_release got=%b exp=%b", w_o, V_NORM);
      end
      n_tests++;
      if (lu_cnt !== exp_lu) begin
         n_fail++;
         $display("FAIL lu_cnt got=%0d exp=%0d", lu_cnt, exp_lu);
      end
      clear_in();
   endtask

   task automatic test_branch_ex();
      tick();
      set_ex(OP_LOAD, 5'd7, 1'b1);
      set_id(OP_BR, 5'd7, 5'd0);
      #1;
      n_tests++;
      if (w_o !== V_BH2) begin
         n_fail++;
         $display("FAIL bh2_c0 got=%b exp=%b", w_o, V_BH2);
      end
      tick();
      set_ex(7'd0, 5'd0, 1'b0);
      set_mem(OP_LOAD, 5'd7, 1'b1);
      #1;
      n_tests++;
      if (w_o !== V_BH1) begin
         n_fail++;
         $display("FAIL bh2_c1 got=%b exp=%b", w_o, V_BH1);
      end
      tick();
      exp_br += 2;
      clear_in();
      #1;
      n_tests++;
      if (w_o !== V_NORM) begin
         n_fail++;
         $display("FAIL bh2_c2 got=%b exp=%b", w_o, V_NORM);
      end
      n_tests++;
      if (br_cnt !== exp_br) begin
         n_fail++;
         $display("FAIL bh2_cnt got=%0d exp=%0d", br_cnt, exp_br);
      end
   endtask

   task automatic test_branch_mem();
      tick();
      set_mem(OP_LOAD, 5'd9, 1'b1);
      set_id(OP_JALR, 5'd9, 5'd0);
      #1;
      n_tests++;
      if (w_o !== V_BH1) begin
         n_fail++;
         $display("FAIL bh1_c0 got=%b exp=%b", w_o, V_BH1);
      end
      tick();
      #1;
      n_tests++;
      if (w_o !== V_BH1) begin
         n_fail++;
         $display("FAIL bh1_c1 got=%b exp=%b", w_o, V_BH1);
      end
      tick();
      exp_br += 2;
      clear_in();
      #1;
      n_tests++;
      if (w_o !== V_NORM || br_cnt !== exp_br) begin
         n_fail++;
         $display("FAIL bh1_done got=%b/%0d exp=%b/%0d",
                  w_o, br_cnt, V_NORM, exp_br);
      end
   endtask

   task automatic test_no_stall();
      logic [6:0] id_op [5] = '{OP_BR, OP_BR, OP_REG, OP_LUI, OP_IMM};
      logic [4:0] id_r1 [5] = '{5'd7, 5'd0, 5'd5, 5'd5, 5'd3};
      logic [4:0] id_r2 [5] = '{5'd0, 5'd0, 5'd1, 5'd0, 5'd5};
      logic [6:0] ex_op [5] = '{OP_IMM, OP_LOAD, OP_LOAD, OP_LOAD, OP_LOAD};
      logic [4:0] ex_rd [5] = '{5'd7, 5'd0, 5'd5, 5'd5, 5'd5};
      logic       ex_we [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         tick();
         set_id(id_op[i], id_r1[i], id_r2[i]);
         set_ex(ex_op[i], ex_rd[i], ex_we[i]);
         #1;
         n_tests++;
         if (w_o !== V_NORM) begin
            n_fail++;
            $display("FAIL nostall_%0d got=%b exp=%b", i, w_o, V_NORM);
         end
      end
      tick();
      clear_in();
      n_tests++;
      if (lu_cnt !== exp_lu || br_cnt !== exp_br) begin
         n_fail++;
         $display("FAIL nostall_cnt got=%0d/%0d exp=%0d/%0d",
                  lu_cnt, br_cnt, exp_lu, exp_br);
      end
   endtask

   task automatic test_dmem_in_br1();
      tick();
      set_ex(OP_LOAD, 5'd7, 1'b1);
      set_id(OP_BR, 5'd0, 5'd7);
      tick();
      exp_br++;
      clear_in();
      dmem_read_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if (w_o !== V_DBR1) begin
            n_fail++;
            $display("FAIL dmiss_%0d got=%b exp=%b", i, w_o, V_DBR1);
         end
         tick();
         exp_mem++;
      end
      dmem_resp_i = 1'b1;
      #1;
      n_tests++;
      if (w_o !== V_BH1) begin
         n_fail++;
         $display("FAIL dmiss_br1 got=%b exp=%b", w_o, V_BH1);
      end
      n_tests++;
      if (mem_cnt !== exp_mem) begin
         n_fail++;
         $display("FAIL dmiss_cnt got=%0d exp=%0d", mem_cnt, exp_mem);
      end
      tick();
      exp_br++;
      clear_in();
      #1;
      n_tests++;
      if (w_o !== V_NORM || br_cnt !== exp_br) begin
         n_fail++;
         $display("FAIL dmiss_done got=%b/%0d exp=%b/%0d",
                  w_o, br_cnt, V_NORM, exp_br);
      end
   endtask

   task automatic test_imem_then_taken();
      tick();
      imem_read_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++;
         if (w_o !== V_IMIS) begin
            n_fail++;
            $display("FAIL imiss_%0d got=%b exp=%b", i, w_o, V_IMIS);
         end
         tick();
         exp_mem++;
      end
      imem_resp_i = 1'b1;
      br_taken_i  = 1'b1;
      #1;
      n_tests++;
      if (w_o !== V_BRT) begin
         n_fail++;
         $display("FAIL taken got=%b exp=%b", w_o, V_BRT);
      end
      tick();
      clear_in();
      n_tests++;
      if (mem_cnt !== exp_mem || lu_cnt !== exp_lu) begin
         n_fail++;
         $display("FAIL imiss_cnt got=%0d/%0d exp=%0d/%0d",
                  mem_cnt, lu_cnt, exp_mem, exp_lu);
      end
   endtask

   task automatic test_priority();
      tick();
      set_ex(OP_LOAD, 5'd4, 1'b1);
      set_id(OP_REG, 5'd2, 5'd4);
      imem_read_i = 1'b1;
      #1;
      n_tests++;
      if (w_o !== V_LU) begin
         n_fail++;
         $display("FAIL prio_lu_imem got=%b exp=%b", w_o, V_LU);
      end
      tick();
      exp_lu++;
      dmem_write_i = 1'b1;
      #1;
      n_tests++;
      if (w_o !== V_ZERO) begin
         n_fail++;
         $display("FAIL prio_dmem got=%b exp=%b", w_o, V_ZERO);
      end
      tick();
      exp_mem++;
      clear_in();
      n_tests++;
      if (lu_cnt !== exp_lu || mem_cnt !== exp_mem) begin
         n_fail++;
         $display("FAIL prio_cnt got=%0d/%0d exp=%0d/%0d",
                  lu_cnt, mem_cnt, exp_lu, exp_mem);
      end
   endtask

   task automatic test_async_reset();
      tick();
      set_ex(OP_LOAD, 5'd7, 1'b1);
      set_id(OP_BR, 5'd7, 5'd0);
      tick();
      clear_in();
      #3 rst = 1'b1;
      #1;
      exp_lu = 0; exp_br = 0; exp_mem = 0;
      n_tests++;
      if (w_o !== V_ZERO) begin
         n_fail++;
         $display("FAIL arst_outs got=%b exp=%b", w_o, V_ZERO);
      end
      n_tests++;
      if (lu_cnt !== 0 || br_cnt !== 0 || mem_cnt !== 0) begin
         n_fail++;
         $display("FAIL arst_cnt got=%0d/%0d/%0d exp=0/0/0",
                  lu_cnt, br_cnt, mem_cnt);
      end
      #1 rst = 1'b0;
      #1;
      n_tests++;
      if (w_o !== V_NORM) begin
         n_fail++;
         $display("FAIL arst_run got=%b exp=%b", w_o, V_NORM);
      end
   endtask

   task automatic test_saturation();
      tick();
      set_ex(OP_LOAD, 5'd3, 1'b1);
      set_id(OP_REG, 5'd3, 5'd3);
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_lu++;
      end
      clear_in();
      n_tests++;
      if (s_lu !== 2'd3 || s_br !== 2'd0 || s_mem !== 2'd0) begin
         n_fail++;
         $display("FAIL sat_small got=%0d/%0d/%0d exp=3/0/0",
                  s_lu, s_br, s_mem);
      end
      n_tests++;
      if (lu_cnt !== exp_lu) begin
         n_fail++;
         $display("FAIL sat_wide got=%0d exp=%0d", lu_cnt, exp_lu);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_ex();
      test_branch_mem();
      test_no_stall();
      test_dmem_in_br1();
      test_imem_then_taken();
      test_priority();
      test_async_reset();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Produces the stall, bubble and freeze controls that the pipeline forwarding logic consumes. This covers `stall_br_haz1`/`stall_br_haz2`, the ID bubble select and the per-stage register load enables.
- Detects load-use hazards, decode-stage branch operand hazards that forwarding cannot cover, and I-cache/D-cache miss waits.
- A small FSM sequences multi-cycle branch stalls.
- Saturating performance counters record the stall cycles.
- Sits beside the forwarding unit in the datapath top.

Parameters:
- CNT_W, 32, width of each stall performance counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- IF_ID_rs1_i  input  5  rs1 of the instruction in ID.
- IF_ID_rs2_i  input  5  rs2 of the instruction in ID.
- IF_ID_opcode_i  input  7  opcode of the instruction in ID.
- ID_EX_rd_i  input  5  destination register in EX.
- ID_EX_opcode_i  input  7  opcode in EX.
- EX_load_regfile_i  input  1  instruction in EX writes the regfile.
- EX_MEM_rd_i  input  5  destination register in MEM.
- EX_MEM_opcode_i  input  7  opcode in MEM.
- MEM_load_regfile_i  input  1  instruction in MEM writes the regfile.
- br_taken_i  input  1  ID resolved a taken branch, jal or jalr.
- imem_read_i  input  1  I-cache request.
- imem_resp_i  input  1  I-cache response.
- dmem_read_i  input  1  D-cache read request.
- dmem_write_i  input  1  D-cache write request.
- dmem_resp_i  input  1  D-cache response.
- pc_load_o  output  1  PC write enable.
- IF_ID_load_o  output  1  IF/ID register enable.
- ID_EX_load_o  output  1  ID/EX register enable.
- EX_MEM_load_o  output  1  EX/MEM register enable.
- MEM_WB_load_o  output  1  MEM/WB register enable.
- IF_ID_flush_o  output  1  load a nop into IF/ID.
- controlmux_sel_o  output  1  0 = normal, 1 = zero (bubble into ID/EX).
- stall_br_haz1_o  output  1  final branch-hazard stall cycle.
- stall_br_haz2_o  output  1  first of two branch-hazard stall cycles.
- lu_stall_cnt_o  output  CNT_W  load-use stall cycles.
- br_stall_cnt_o  output  CNT_W  branch stall cycles.
- mem_stall_cnt_o  output  CNT_W  cache-wait cycles.

Behaviour:
- **Reset.** FSM enters RUN and all counters clear. While rst is high, every load enable is 0, and flush, controlmux_sel and both stall outputs are 0.
- **Register use.**
  - uses_rs1 holds for op_reg, op_imm, op_load, op_store, op_br and op_jalr.
  - uses_rs2 holds for op_reg, op_store and op_br.
  - Register x0 never creates a hazard.
- **Hazard definitions.**
  - dmem_busy = (dmem_read_i | dmem_write_i) & ~dmem_resp_i.
  - imem_busy = imem_read_i & ~imem_resp_i.
  - A dependency on a stage means EX_load_regfile_i (for EX) or MEM_load_regfile_i (for MEM) is set, rd != 0, and rd matches a used source.
  - br_id: IF_ID opcode is op_br or op_jalr.
  - lu: ~br_id, ID_EX opcode is op_load, and there is a dependency on EX.
  - bh2: br_id, ID_EX opcode is op_load, and there is a dependency on EX.
  - bh1: br_id, EX_MEM opcode is op_load, and there is a dependency on MEM. ALU producers never stall (they are forwarded).
- **Priority** is dmem_busy > FSM stall state > bh2 > bh1 > lu > imem_busy > br_taken.
- **FSM states:** RUN, BR2, BR1. Outputs below are combinational from state and inputs.
- **dmem_busy (any state).**
  - All five load enables are 0; flush = 0, controlmux_sel = 0.
  - stall_br_haz outputs keep the value implied by the current state.
  - State holds; mem_stall_cnt increments.
- **RUN with bh2.**
  - pc_load = 0, IF_ID_load = 0, controlmux_sel = 1; remaining stage enables = 1.
  - stall_br_haz2 = 1; next state BR1; br_stall_cnt increments.
- **RUN with bh1.** Same enables as bh2, but stall_br_haz1 = 1; next state BR1.
- **BR1 (no dmem_busy).**
  - Same enables, with stall_br_haz1 = 1; next state RUN.
  - This stall is final: bh conditions are not re-evaluated in BR1.
- **BR2** is reached only from RUN with bh2 when the team enables the 3-stage branch variant.
  - With that variant disabled, BR2 is unreachable.
  - BR2 → BR1, with stall_br_haz2 = 1.
- **RUN with lu.** pc_load = 0, IF_ID_load = 0, controlmux_sel = 1 for exactly one cycle; lu_stall_cnt increments.
- **RUN with imem_busy.**
  - pc_load = 0, IF_ID_load = 1, IF_ID_flush = 1; downstream enables = 1.
  - mem_stall_cnt increments.
- **RUN with br_taken_i.** IF_ID_flush = 1, all enables = 1.
- **Otherwise:** all enables = 1; flush, controlmux_sel and stall outputs = 0.
- **Counters** saturate at all-ones. Only one counter increments per cycle, selected by the priority above.
- **rst asserted mid-stall** returns to RUN immediately and asynchronously.

Test Plan:
- **Load-use:** `lw x5` in EX, `add x6,x5,x1` in ID → one cycle with pc_load = 0, IF_ID_load = 0, controlmux_sel = 1; next cycle all enables 1; lu_stall_cnt = 1.
- **Branch on load in EX:** `lw x7` in EX, `beq x7,x0` in ID → stall_br_haz2 = 1 in cycle 0, stall_br_haz1 = 1 in cycle 1 (state BR1), RUN in cycle 2; br_stall_cnt = 2.
- **Branch on ALU producer:** `addi x7` in EX, `beq x7` in ID → no stall and all enables 1; `rd = x0` likewise produces no stall.
- **D-cache miss during BR1:** dmem_read = 1 and dmem_resp = 0 for 3 cycles → all enables 0, state held at BR1 and stall_br_haz1 held at 1; BR1 completes after resp; mem_stall_cnt = 3.
- **I-cache miss, then taken branch:** imem_busy for 2 cycles → pc_load = 0 with IF_ID_flush = 1; then br_taken = 1 → flush = 1 with pc_load = 1.
- **Async reset mid-BR1:** rst asserted between clock edges → outputs drop to 0 immediately; after release the state is RUN and all counters are 0.
